// File: rtl/gpr_pkg.sv
// -----------------------------------------------------------------------------
// gpr_pkg
//   Shared constants and helpers for the multi-port general-purpose register
//   file (gpr_file_mp) and its pending-write scoreboard.
//   Contents:
//     GPR_ZERO          address of the hardwired-zero register
//     GPR_DW_DEFAULT    default data width
//     GPR_NREG_DEFAULT  default register count
//     gpr_aw()          address width for a given register count
// -----------------------------------------------------------------------------
package gpr_pkg;

   localparam int GPR_ZERO         = 0;
   localparam int GPR_DW_DEFAULT   = 32;
   localparam int GPR_NREG_DEFAULT = 32;

   // Address width for nreg registers; a two-entry file still needs one bit.
   function automatic int gpr_aw(input int nreg);
      return (nreg <= 2) ? 1 : $clog2(nreg);
   endfunction

endpackage : gpr_pkg

// File: rtl/gpr_file_mp_if.sv
// -----------------------------------------------------------------------------
// gpr_file_mp_if
//   Bundles the read, write and issue signals of the multi-port register file.
//   The master side (decode / writeback) drives addresses, write data and the
//   issue strobe; the slave side (the register file) returns read data, the
//   per-read-port Busy flags and the write-conflict flag.
//   Signals:
//     RA          NR*AW  read addresses, port i at [i*AW +: AW]
//     RD          NR*DW  read data, port i at [i*DW +: DW]
//     WE          NW     write enable per write port
//     WA          NW*AW  write addresses
//     WD          NW*DW  write data
//     Issue_V     1      an instruction writing Issue_A issues this cycle
//     Issue_A     AW     destination register of the issued instruction
//     Busy        NR     read port source has an outstanding write
//     Wr_Conflict 1      two enabled write ports share a nonzero address
// -----------------------------------------------------------------------------
interface gpr_file_mp_if
   import gpr_pkg::*;
#(
   parameter int DW   = GPR_DW_DEFAULT,
   parameter int NREG = GPR_NREG_DEFAULT,
   parameter int NR   = 2,
   parameter int NW   = 1,
   parameter int AW   = gpr_aw(NREG)
);

   logic [NR*AW-1:0] RA;
   logic [NR*DW-1:0] RD;
   logic [NW-1:0]    WE;
   logic [NW*AW-1:0] WA;
   logic [NW*DW-1:0] WD;
   logic             Issue_V;
   logic [AW-1:0]    Issue_A;
   logic [NR-1:0]    Busy;
   logic             Wr_Conflict;

   modport master (
      output RA, WE, WA, WD, Issue_V, Issue_A,
      input  RD, Busy, Wr_Conflict
   );

   modport slave (
      input  RA, WE, WA, WD, Issue_V, Issue_A,
      output RD, Busy, Wr_Conflict
   );

endinterface : gpr_file_mp_if

// File: rtl/gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
//   One pending bit per nonzero register. A bit is set when an instruction
//   targeting that register issues and cleared when any write port writes it
//   back; a same-cycle issue wins over the writeback so the newer producer is
//   still tracked. Busy tells the stall unit that a read port's source is not
//   yet available (unless the value is being bypassed this very cycle).
//   Ports:
//     Clk          clock
//     Rst          synchronous active-high reset (clears every pending bit)
//     ra_i         NR*AW  read addresses
//     we_i         NW     write enables
//     wa_i         NW*AW  write addresses
//     issue_v_i    1      issue strobe
//     issue_a_i    AW     issue destination
//     busy_o       NR     per read port hazard flag
// -----------------------------------------------------------------------------
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int NREG   = GPR_NREG_DEFAULT,
   parameter int NR     = 2,
   parameter int NW     = 1,
   parameter int BYPASS = 1,
   parameter int AW     = gpr_aw(NREG)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [NR*AW-1:0] ra_i,
   input  logic [NW-1:0]    we_i,
   input  logic [NW*AW-1:0] wa_i,
   input  logic             issue_v_i,
   input  logic [AW-1:0]    issue_a_i,
   output logic [NR-1:0]    busy_o
);

   logic [NREG-1:1] pend_q;
   logic [NREG-1:1] pend_d;
   logic [NREG-1:0] pend_full;

   // Register 0 has no pending bit; padding a constant zero lets the read
   // address index the vector directly.
   assign pend_full = {pend_q, 1'b0};

   // NOTE: combinational blocks assign a default to every output first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      pend_d = pend_q;
      for (int r = 1; r < NREG; r++) begin
         for (int j = 0; j < NW; j++) begin
            if (we_i[j] && wa_i[j*AW +: AW] == AW'(r)) begin
               pend_d[r] = 1'b0;
            end
         end
         // Evaluated after the clear so a same-cycle issue keeps the bit set.
         if (issue_v_i && issue_a_i == AW'(r)) begin
            pend_d[r] = 1'b1;
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   always_comb begin
      busy_o = '0;
      for (int i = 0; i < NR; i++) begin
         logic          hit;
         logic [AW-1:0] ra;
         ra  = ra_i[i*AW +: AW];
         hit = 1'b0;
         for (int j = 0; j < NW; j++) begin
            if (we_i[j] && wa_i[j*AW +: AW] == ra) begin
               hit = 1'b1;
            end
         end
         if (ra != AW'(GPR_ZERO)) begin
            busy_o[i] = pend_full[ra] & ~((BYPASS != 0) & hit);
         end
      end
   end

endmodule : gpr_scoreboard

// File: rtl/gpr_file_mp.sv
// -----------------------------------------------------------------------------
// gpr_file_mp
//   Multi-port general-purpose register file: NR combinational read ports,
//   NW write ports committing on the rising clock edge, optional same-cycle
//   write-to-read bypass, and a pending-write scoreboard for hazard detection.
//   Register 0 always reads zero and ignores writes. When several enabled
//   write ports target the same register the highest port index wins and
//   Wr_Conflict is raised for that cycle.
//   Ports:
//     Clk   clock, all state updates on posedge
//     Rst   synchronous active-high reset (registers and pending bits cleared)
//     bus   gpr_file_mp_if slave: RA/RD, WE/WA/WD, Issue_V/Issue_A,
//           Busy, Wr_Conflict
// -----------------------------------------------------------------------------
module gpr_file_mp
   import gpr_pkg::*;
#(
   parameter int DW     = GPR_DW_DEFAULT,
   parameter int NREG   = GPR_NREG_DEFAULT,
   parameter int NR     = 2,
   parameter int NW     = 1,
   parameter int BYPASS = 1,
   // Derived from NREG; leave at its default.
   parameter int AW     = gpr_aw(NREG)
) (
   input  logic          Clk,
   input  logic          Rst,
   gpr_file_mp_if.slave  bus
);

   logic [AW-1:0] ra [NR];
   logic [AW-1:0] wa [NW];
   logic [DW-1:0] wd [NW];

   logic [DW-1:0] regs_q [NREG-1:1];
   logic [DW-1:0] regs_d [NREG-1:1];

   logic [NR*DW-1:0] rd_flat;
   logic             conflict;

   // Split the flat interface vectors into per-port fields.
   always_comb begin
      for (int i = 0; i < NR; i++) begin
         ra[i] = bus.RA[i*AW +: AW];
      end
      for (int j = 0; j < NW; j++) begin
         wa[j] = bus.WA[j*AW +: AW];
         wd[j] = bus.WD[j*DW +: DW];
      end
   end

   // Write ports are scanned in ascending order so the highest enabled port
   // targeting a register supplies its next value. Register 0 has no storage,
   // which is what makes writes to it disappear.
   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         regs_d[r] = regs_q[r];
         for (int j = 0; j < NW; j++) begin
            if (bus.WE[j] && wa[j] == AW'(r)) begin
               regs_d[r] = wd[j];
            end
         end
      end
   end

   // NOTE: the storage is a flop array rather than a RAM macro, so clearing
   // every entry on reset is legal here; a RAM-based file could not do this.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int r = 1; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read muxes: zero register first, then array, then (optionally) the
   // highest-indexed write port hitting the same address.
   always_comb begin
      rd_flat = '0;
      for (int i = 0; i < NR; i++) begin
         logic [DW-1:0] val;
         val = '0;
         if (ra[i] != AW'(GPR_ZERO)) begin
            val = regs_q[ra[i]];
            if (BYPASS != 0) begin
               for (int j = 0; j < NW; j++) begin
                  if (bus.WE[j] && wa[j] == ra[i]) begin
                     val = wd[j];
                  end
               end
            end
         end
         rd_flat[i*DW +: DW] = val;
      end
   end

   // Pairwise compare of enabled write ports; writes to register 0 never
   // conflict because they are discarded anyway.
   always_comb begin
      conflict = 1'b0;
      for (int j = 0; j < NW; j++) begin
         for (int k = j + 1; k < NW; k++) begin
            if (bus.WE[j] && bus.WE[k] && wa[j] == wa[k] &&
                wa[j] != AW'(GPR_ZERO)) begin
               conflict = 1'b1;
            end
         end
      end
   end

   assign bus.RD          = rd_flat;
   assign bus.Wr_Conflict = conflict;

   gpr_scoreboard #(
      .NREG   (NREG),
      .NR     (NR),
      .NW     (NW),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_scoreboard (
      .Clk       (Clk),
      .Rst       (Rst),
      .ra_i      (bus.RA),
      .we_i      (bus.WE),
      .wa_i      (bus.WA),
      .issue_v_i (bus.Issue_V),
      .issue_a_i (bus.Issue_A),
      .busy_o    (bus.Busy)
   );

endmodule : gpr_file_mp
